// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   XLEN        : data/address word width
//   state_e     : sequencer state encoding (IDLE=0, RUN=1, HALT=2, FAULT=3)
//   fetch_ent_t : one buffered fetch, {pc, instr}
//   pc_bad()    : true when a PC is misaligned or beyond the last valid word
package fetch_ctrl_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_ent_t;

  function automatic logic pc_bad(input logic [XLEN-1:0] pc, input int unsigned nmem);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[XLEN-1:2]} >= nmem);
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bus: instruction-memory address/data plus the decode-side
// valid/ready handshake carrying the head instruction and its PC.
//   master : fetch sequencer side
//   slave  : memory + decode side
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;
  logic [XLEN-1:0] im_addr;
  logic [XLEN-1:0] im_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (output im_addr, out_valid, out_instr, out_pc,
                  input  im_data, out_ready);
  modport slave  (input  im_addr, out_valid, out_instr, out_pc,
                  output im_data, out_ready);
endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: 2-entry FIFO of {pc, instr}. Entry 0 is always the head, so
// the head outputs come straight from a register.
//   clk, rst     : clock, async active-high reset
//   push_i/data_i: write at tail (caller guarantees space)
//   pop_i        : remove head (ignored when empty)
//   flush_i      : empty the buffer; overrides push and pop
//   count_o      : occupancy 0..2
//   head_o       : head entry
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  fetch_ent_t data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [1:0] count_o,
  output fetch_ent_t head_o
);
  fetch_ent_t [1:0] ent_q, ent_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_ok;
  logic [1:0]       cnt_pop;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  // occupancy after the pop, which is also the tail slot for a push
  assign cnt_pop = cnt_q - {1'b0, pop_ok};

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      if (pop_ok) ent_d[0] = ent_q[1];
      cnt_d = cnt_pop;
      if (push_i && cnt_pop != 2'd2) begin
        ent_d[cnt_pop[0]] = data_i;
        cnt_d = cnt_pop + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = ent_q[0];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, drives the memory
// address, captures {pc, im_data} into a 2-entry buffer and presents the head
// to decode. Handles start/halt, redirect with flush, and PC faults.
//   clk, reset            : clock, async active-high reset
//   start, halt           : run control levels
//   redirect_valid/_pc    : taken branch/jump target
//   bus (master)          : im_addr/im_data, out_valid/out_ready/out_instr/out_pc
//   busy                  : sequencer is in RUN
//   fault                 : sticky PC fault, cleared only by reset
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     NMEM     = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_ctrl_if.master    bus,
  output logic            busy,
  output logic            fault
);
  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            busy_q, fault_q;

  logic            in_run, redir, fault_cond, pop, push;
  logic [1:0]      count;
  fetch_ent_t      head, wr_ent;

  assign in_run     = (state_q == ST_RUN);
  assign redir      = redirect_valid && (in_run || state_q == ST_HALT);
  assign fault_cond = in_run && pc_bad(pc_q, NMEM);
  assign pop        = bus.out_valid && bus.out_ready;
  // a full buffer still accepts when the head leaves this same edge
  assign push       = in_run && !redirect_valid && !fault_cond && !halt &&
                      (count != 2'd2 || pop);
  assign wr_ent     = '{pc: pc_q, instr: bus.im_data};

  fetch_buf u_buf (
    .clk    (clk),
    .rst    (reset),
    .push_i (push),
    .data_i (wr_ent),
    .pop_i  (pop),
    .flush_i(redir),
    .count_o(count),
    .head_o (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (redir)     pc_q <= redirect_pc;
      else if (push) pc_q <= pc_q + 32'd4;

      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
        end
        ST_RUN: begin
          // a bad PC stops the sequencer even if halt is also requested
          if (fault_cond) begin
            state_q <= ST_FAULT;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end else if (halt) begin
            state_q <= ST_HALT;
            busy_q  <= 1'b0;
          end
        end
        ST_HALT: if (start && !halt) begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
        end
        default: ;  // FAULT is left only through reset
      endcase
    end
  end

  assign bus.im_addr   = pc_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign busy          = busy_q;
  assign fault         = fault_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  localparam int MN = 128;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, halt = 1'b0, rv = 1'b0, ready = 1'b0;
  logic [31:0] rpc = '0;
  logic busy_a, fault_a, busy_b, fault_b;

  int ntot = 0;
  int npass = 0;

  // reference model: queue of {pc, instr}, pc, state
  logic [63:0] mq[$];
  logic [31:0] mpc;
  int          mst;

  always #5 clk = ~clk;

  fetch_ctrl_if ifa ();
  fetch_ctrl_if ifb ();

  // memory word i holds 0x1000 + i
  assign ifa.im_data   = 32'h1000 + {25'd0, ifa.im_addr[8:2]};
  assign ifb.im_data   = 32'h1000 + {25'd0, ifb.im_addr[8:2]};
  assign ifa.out_ready = ready;
  assign ifb.out_ready = ready;

  fetch_ctrl #(.RESET_PC(32'h0), .NMEM(MN)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .redirect_valid(rv), .redirect_pc(rpc), .bus(ifa),
    .busy(busy_a), .fault(fault_a));

  fetch_ctrl #(.RESET_PC(32'h0), .NMEM(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .redirect_valid(rv), .redirect_pc(rpc), .bus(ifb),
    .busy(busy_b), .fault(fault_b));

  task automatic model_reset();
    mq.delete();
    mpc = 32'h0;
    mst = S_IDLE;
  endtask

  // advances the model by one edge using the inputs currently applied
  task automatic model_step();
    int sz = mq.size();
    bit pop = (sz > 0) && ready;
    bit bad = (mpc % 4 != 0) || ((mpc / 4) >= MN);
    bit take_redir = rv && (mst == S_RUN || mst == S_HALT);
    bit push = (mst == S_RUN) && !rv && !bad && !halt && (sz < 2 || pop);
    logic [63:0] w = {mpc, 32'h1000 + (mpc / 4)};
    if (take_redir) begin
      mq.delete();
      mpc = rpc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(w);
        mpc = mpc + 4;
      end
    end
    case (mst)
      S_IDLE: if (start) mst = S_RUN;
      S_RUN:  if (bad) mst = S_FAULT; else if (halt) mst = S_HALT;
      S_HALT: if (start && !halt) mst = S_RUN;
      default: ;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; halt = 0; rv = 0; rpc = 0; ready = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #3;
    ntot++;
    if ({ifa.out_valid, busy_a, fault_a, ifa.im_addr, ifa.out_pc, ifa.out_instr} !== {3'b000, 96'h0})
      $display("FAIL reset: v=%b busy=%b fault=%b addr=%h pc=%h instr=%h exp all zero",
               ifa.out_valid, busy_a, fault_a, ifa.im_addr, ifa.out_pc, ifa.out_instr);
    else npass++;
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    ready = 1; start = 1;
    tick();
    start = 0;
    ntot++;
    if ({busy_a, ifa.out_valid, ifa.im_addr} !== {2'b10, 32'h0})
      $display("FAIL stream_enter: busy=%b v=%b addr=%h exp 1 0 0", busy_a, ifa.out_valid, ifa.im_addr);
    else npass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      ntot++;
      if ({ifa.out_valid, ifa.out_pc, ifa.out_instr} !== {1'b1, 32'(4*i), 32'h1000 + 32'(i)})
        $display("FAIL stream_%0d: v=%b pc=%h instr=%h exp 1 %h %h", i, ifa.out_valid,
                 ifa.out_pc, ifa.out_instr, 4*i, 32'h1000 + i);
      else npass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 0; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    ntot++;
    if ({ifa.out_valid, ifa.im_addr, ifa.out_pc, ifa.out_instr} !== {1'b1, 32'h8, 32'h0, 32'h1000})
      $display("FAIL bp_hold: v=%b addr=%h pc=%h instr=%h exp 1 8 0 1000", ifa.out_valid,
               ifa.im_addr, ifa.out_pc, ifa.out_instr);
    else npass++;
    ready = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ntot++;
      if ({ifa.out_valid, ifa.out_pc, ifa.out_instr} !== {1'b1, 32'(4*k), 32'h1000 + 32'(k)})
        $display("FAIL bp_resume_%0d: v=%b pc=%h instr=%h exp 1 %h %h", k, ifa.out_valid,
                 ifa.out_pc, ifa.out_instr, 4*k, 32'h1000 + k);
      else npass++;
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    ready = 0; start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    rv = 1; rpc = 32'h40; ready = 1;
    tick();
    rv = 0;
    ntot++;
    if ({ifa.out_valid, ifa.im_addr} !== {1'b0, 32'h40})
      $display("FAIL redir_flush: v=%b addr=%h exp 0 40", ifa.out_valid, ifa.im_addr);
    else npass++;
    tick();
    ntot++;
    if ({ifa.out_valid, ifa.out_pc, ifa.out_instr} !== {1'b1, 32'h40, 32'h1010})
      $display("FAIL redir_head: v=%b pc=%h instr=%h exp 1 40 1010", ifa.out_valid, ifa.out_pc, ifa.out_instr);
    else npass++;
  endtask

  task automatic test_halt_resume();
    do_reset();
    ready = 1; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    halt = 1;
    tick();
    tick();
    ntot++;
    if ({busy_a, ifa.out_valid, ifa.im_addr} !== {2'b00, 32'h10})
      $display("FAIL halt: busy=%b v=%b addr=%h exp 0 0 10", busy_a, ifa.out_valid, ifa.im_addr);
    else npass++;
    halt = 0; start = 1;
    tick();
    start = 0;
    tick();
    ntot++;
    if ({busy_a, ifa.out_valid, ifa.out_pc, ifa.out_instr} !== {2'b11, 32'h10, 32'h1004})
      $display("FAIL resume: busy=%b v=%b pc=%h instr=%h exp 1 1 10 1004", busy_a,
               ifa.out_valid, ifa.out_pc, ifa.out_instr);
    else npass++;
  endtask

  task automatic test_runoff();
    do_reset();
    ready = 1; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      ntot++;
      if ({ifb.out_valid, ifb.out_pc, ifb.out_instr} !== {1'b1, 32'(4*k), 32'h1000 + 32'(k)})
        $display("FAIL runoff_word_%0d: v=%b pc=%h instr=%h exp 1 %h %h", k, ifb.out_valid,
                 ifb.out_pc, ifb.out_instr, 4*k, 32'h1000 + k);
      else npass++;
    end
    tick();
    ntot++;
    if ({fault_b, busy_b, ifb.out_valid, ifb.im_addr} !== {3'b100, 32'h10})
      $display("FAIL runoff_fault: fault=%b busy=%b v=%b addr=%h exp 1 0 0 10", fault_b,
               busy_b, ifb.out_valid, ifb.im_addr);
    else npass++;
    start = 1;
    repeat (3) tick();
    start = 0;
    ntot++;
    if ({fault_b, busy_b, ifb.out_valid} !== 3'b100)
      $display("FAIL runoff_sticky: fault=%b busy=%b v=%b exp 1 0 0", fault_b, busy_b, ifb.out_valid);
    else npass++;
    do_reset();
    #1;
    ntot++;
    if (fault_b !== 1'b0)
      $display("FAIL runoff_clear: fault=%b exp 0", fault_b);
    else npass++;
  endtask

  task automatic test_misaligned();
    do_reset();
    ready = 1; start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    rv = 1; rpc = 32'h6;
    tick();
    rv = 0;
    ntot++;
    if ({fault_a, busy_a, ifa.out_valid, ifa.im_addr} !== {3'b010, 32'h6})
      $display("FAIL misal_accept: fault=%b busy=%b v=%b addr=%h exp 0 1 0 6", fault_a,
               busy_a, ifa.out_valid, ifa.im_addr);
    else npass++;
    tick();
    ntot++;
    if ({fault_a, busy_a, ifa.out_valid, ifa.im_addr} !== {3'b100, 32'h6})
      $display("FAIL misal_fault: fault=%b busy=%b v=%b addr=%h exp 1 0 0 6", fault_a,
               busy_a, ifa.out_valid, ifa.im_addr);
    else npass++;
  endtask

  task automatic test_random();
    int fault_cycles = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ready = ($urandom % 4) != 0;
      halt  = ($urandom % 16) == 0;
      start = ($urandom % 4) == 0;
      rv    = ($urandom % 20) == 0;
      rpc   = 32'($urandom_range(0, 127)) << 2;
      if ($urandom % 12 == 0) rpc = rpc | 32'h1;
      if ($urandom % 12 == 0) rpc = 32'h200;
      tick();
      ntot++;
      if ({ifa.out_valid, busy_a, fault_a, ifa.im_addr} !==
          {mq.size() > 0, mst == S_RUN, mst == S_FAULT, mpc})
        $display("FAIL rand_ctl_%0d: v=%b busy=%b fault=%b addr=%h exp %b %b %b %h", c,
                 ifa.out_valid, busy_a, fault_a, ifa.im_addr, mq.size() > 0,
                 mst == S_RUN, mst == S_FAULT, mpc);
      else npass++;
      if (mq.size() > 0) begin
        ntot++;
        if ({ifa.out_pc, ifa.out_instr} !== mq[0])
          $display("FAIL rand_head_%0d: got %h_%h exp %h", c, ifa.out_pc, ifa.out_instr, mq[0]);
        else npass++;
      end
      fault_cycles = (mst == S_FAULT) ? fault_cycles + 1 : 0;
      if (fault_cycles > 4) begin
        do_reset();
        fault_cycles = 0;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready = 0; start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    ntot++;
    if ({ifa.out_valid, busy_a, fault_a, ifa.im_addr} !== {3'b000, 32'h0})
      $display("FAIL async_reset: v=%b busy=%b fault=%b addr=%h exp 0 0 0 0",
               ifa.out_valid, busy_a, fault_a, ifa.im_addr);
    else npass++;
    do_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_halt_resume();
    test_runoff();
    test_misaligned();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
